// File: rtl/datamemory_master.sv
// Load/store initiator for the word-addressed datamemory port.
// Sub-word stores are performed as read-modify-write; sub-word loads are extracted and extended.
module datamemory_master #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_Addr,
    output logic              mem_We,
    output logic [DATA_W-1:0] mem_Data_in,
    input  logic [DATA_W-1:0] mem_Data_out
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    localparam logic [2:0] LAST_RD = 3'(READ_LAT - 1);

    state_t            state, state_next;
    logic [2:0]        rd_cnt, rd_cnt_next;
    logic              wr_q, wr_next;
    logic [1:0]        size_q, size_next;
    logic              sgn_q, sgn_next;
    logic [1:0]        off_q, off_next;
    logic [15:0]       wdata_q, wdata_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] din_next, rdata_next;
    logic              err_next;
    logic              misaligned;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] load_data, merge_data, lane_mask, lane_data;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_We    = (state != WRITE);

    assign misaligned = (req_size == SZ_ILL) ||
                        (req_size == SZ_HALF && req_addr[0]) ||
                        (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    // Lane extraction for loads and lane replacement for read-modify-write stores
    always_comb begin
        byte_lane = 8'(mem_Data_out >> {off_q, 3'b000});
        half_lane = 16'(mem_Data_out >> {off_q[1], 4'b0000});
        load_data = mem_Data_out;
        lane_mask = '0;
        lane_data = '0;
        case (size_q)
            SZ_BYTE: begin
                load_data = {{(DATA_W-8){sgn_q & byte_lane[7]}}, byte_lane};
                lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF} << {off_q, 3'b000};
                lane_data = {{(DATA_W-8){1'b0}}, wdata_q[7:0]} << {off_q, 3'b000};
            end
            SZ_HALF: begin
                load_data = {{(DATA_W-16){sgn_q & half_lane[15]}}, half_lane};
                lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << {off_q[1], 4'b0000};
                lane_data = {{(DATA_W-16){1'b0}}, wdata_q} << {off_q[1], 4'b0000};
            end
            default: ;
        endcase
        merge_data = (mem_Data_out & ~lane_mask) | lane_data;
    end

    always_comb begin
        state_next  = state;
        rd_cnt_next = rd_cnt;
        wr_next     = wr_q;
        size_next   = size_q;
        sgn_next    = sgn_q;
        off_next    = off_q;
        wdata_next  = wdata_q;
        addr_next   = mem_Addr;
        din_next    = mem_Data_in;
        rdata_next  = rsp_rdata;
        err_next    = rsp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    wr_next     = req_wr;
                    size_next   = req_size;
                    sgn_next    = req_signed;
                    off_next    = req_addr[1:0];
                    wdata_next  = req_wdata[15:0];
                    rd_cnt_next = '0;
                    rdata_next  = '0;
                    err_next    = 1'b0;
                    // Errors skip the memory entirely so the bus keeps its previous address
                    if (misaligned) begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        addr_next = {2'b00, req_addr[ADDR_W-1:2]};
                        if (req_wr && req_size == SZ_WORD) begin
                            din_next   = req_wdata;
                            state_next = WRITE;
                        end else begin
                            state_next = READ;
                        end
                    end
                end
            end
            READ: begin
                if (rd_cnt == LAST_RD) begin
                    if (wr_q) begin
                        din_next   = merge_data;
                        state_next = WRITE;
                    end else begin
                        rdata_next = load_data;
                        state_next = RESP;
                    end
                end else begin
                    rd_cnt_next = rd_cnt + 3'd1;
                end
            end
            WRITE: state_next = RESP;
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            wr_q        <= 1'b0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
            mem_Addr    <= '0;
            mem_Data_in <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_next;
            rd_cnt      <= rd_cnt_next;
            wr_q        <= wr_next;
            size_q      <= size_next;
            sgn_q       <= sgn_next;
            off_q       <= off_next;
            wdata_q     <= wdata_next;
            mem_Addr    <= addr_next;
            mem_Data_in <= din_next;
            rsp_rdata   <= rdata_next;
            rsp_err     <= err_next;
        end
    end
endmodule

// File: tb/tb_datamemory_master.sv
// Self-checking bench for datamemory_master: directed scenarios plus random traffic
// checked against a word-array reference model of the memory.
module tb_datamemory_master;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int READ_LAT = 1;

    logic        Clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_wr, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_Addr, mem_Data_in, mem_Data_out;
    logic        mem_We;

    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic [31:0] model_addr;
    logic        seed_mem;
    int          tests = 0;
    int          failures = 0;

    logic [31:0] got;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_wr, r_sgn;

    datamemory_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .Clk(Clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_Addr(mem_Addr), .mem_We(mem_We), .mem_Data_in(mem_Data_in),
        .mem_Data_out(mem_Data_out)
    );

    always #5 Clk = ~Clk;

    // Memory: combinational read, writes on the edge that ends an mem_We=0 cycle
    assign mem_Data_out = mem[mem_Addr[3:0]];
    always @(posedge Clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else if (mem_We === 1'b0) begin
            mem[mem_Addr[3:0]] <= mem_Data_in;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full transaction; latency is the number of edges after acceptance until rsp_valid is registered
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int hold, output logic [31:0] rd);
        int          idx, cycles, we_low, exp_lat, exp_we_low;
        longint      oldv, w, m, lane;
        logic [31:0] exp_word, exp_rdata, exp_addr, din_seen;
        logic        exp_err, addr_ok;
        idx       = int'(addr[5:2]);
        oldv      = longint'(ref_mem[idx]);
        exp_word  = ref_mem[idx];
        exp_rdata = 32'd0;
        exp_err   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                    (size == 2'b10 && addr[1:0] != 2'b00);
        m = (size == 2'b00) ? 64'd256 : 64'd65536;
        w = (size == 2'b00) ? (64'd1 << (8 * addr[1:0])) : (64'd1 << (16 * addr[1]));
        lane = (oldv / w) % m;
        exp_lat = 0;
        exp_we_low = 0;
        if (!exp_err) begin
            model_addr = addr / 4;
            if (wr) begin
                exp_we_low = 1;
                if (size == 2'b10) begin
                    exp_word = wdata;
                    exp_lat  = 1;
                end else begin
                    exp_word = 32'(oldv - lane * w + (longint'(wdata) % m) * w);
                    exp_lat  = READ_LAT + 1;
                end
            end else begin
                exp_lat = READ_LAT;
                if (size == 2'b10) exp_rdata = ref_mem[idx];
                else begin
                    if (sgn && lane >= m / 2) lane = lane - m;
                    exp_rdata = 32'(lane);
                end
            end
        end
        exp_addr = model_addr;

        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_wr = wr; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        cycles = 0; we_low = 0; addr_ok = 1'b1; din_seen = 32'd0;
        while (rsp_valid !== 1'b1 && cycles < 20) begin
            if (mem_We === 1'b0) begin
                we_low++;
                din_seen = mem_Data_in;
            end
            if (mem_Addr !== exp_addr) addr_ok = 1'b0;
            @(posedge Clk); #1;
            cycles++;
        end
        if (mem_Addr !== exp_addr) addr_ok = 1'b0;
        checkOutput("latency", 32'(cycles), 32'(exp_lat));
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("we_low_cycles", 32'(we_low), 32'(exp_we_low));
        checkOutput("mem_addr_held", {31'd0, addr_ok}, 32'd1);
        checkOutput("we_high_at_rsp", {31'd0, mem_We}, 32'd1);
        if (exp_we_low == 1) checkOutput("write_data", din_seen, exp_word);
        rd = rsp_rdata;
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_addr = 32'h8;
            @(posedge Clk); #1;
            checkOutput("bp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("bp_rdata", rsp_rdata, exp_rdata);
            checkOutput("bp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge Clk); #1;
        rsp_ready = 1'b0;
        checkOutput("rsp_released", {31'd0, rsp_valid}, 32'd0);
        checkOutput("req_ready_after", {31'd0, req_ready}, 32'd1);
        if (!exp_err && wr) ref_mem[idx] = exp_word;
        checkOutput("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        seed_mem = 1'b1; model_addr = 32'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'h11223344;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_mem_we", {31'd0, mem_We}, 32'd1);
        checkOutput("reset_mem_addr", mem_Addr, 32'd0);
        checkOutput("reset_mem_din", mem_Data_in, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        seed_mem = 1'b0;
        @(negedge Clk) rst = 1'b1;
        @(posedge Clk); #1;

        // Word store then load back
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd0, 32'd33400, 0, got);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 0, got);
        checkOutput("tp_word_load", got, 32'd33400);

        // Byte store into word 1 and sub-word loads from it
        applyStimulus(1'b1, 2'b00, 1'b0, 32'd5, 32'h000000AB, 0, got);
        checkOutput("tp_byte_merge", mem[1], 32'h1122AB44);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'd5, 32'd0, 0, got);
        checkOutput("tp_sbyte", got, 32'hFFFFFFAB);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 0, got);
        checkOutput("tp_ubyte", got, 32'h000000AB);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'd6, 32'd0, 0, got);
        checkOutput("tp_shalf", got, 32'h00001122);

        // Misaligned and illegal-size requests
        applyStimulus(1'b0, 2'b01, 1'b0, 32'd3, 32'd0, 0, got);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'd2, 32'hDEADBEEF, 0, got);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 0, got);

        // Backpressure on a load
        applyStimulus(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 3, got);
        checkOutput("tp_bp_load", got, 32'h1122AB44);

        // Reset while a byte store to word 0 is reading
        req_wr = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'd0;
        req_wdata = 32'h0000005A; req_valid = 1'b1;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        checkOutput("rst_in_read_we", {31'd0, mem_We}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_mid_we", {31'd0, mem_We}, 32'd1);
        checkOutput("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk) rst = 1'b1;
        model_addr = 32'd0;
        @(posedge Clk); #1;
        checkOutput("rst_after_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_after_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_word0_kept", mem[0], 32'd33400);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            r_addr  = 32'($urandom_range(0, 63));
            r_size  = 2'($urandom_range(0, 3));
            r_wr    = 1'($urandom_range(0, 1));
            r_sgn   = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            applyStimulus(r_wr, r_size, r_sgn, r_addr, r_wdata, int'($urandom_range(0, 2)), got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
